// File: rtl/receive_response.sv
// Response collector for the SD-card SPI path: hunts for the R1 token, then
// optionally shifts in an R3/R7 trailer or polls out R1b busy.
module receive_response #(
    parameter int NCR_MAX  = 8,
    parameter int BUSY_MAX = 65535
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  recvData_i,
    output logic        recvReq_o,
    input  logic        recvAck_i,
    input  logic [1:0]  respType_i,
    input  logic        respRecv_i,
    output logic        respAck_o,
    output logic [7:0]  r1_o,
    output logic [31:0] payload_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_HUNT,
        PH_PAYLOAD,
        PH_BUSY
    } phase_e;

    localparam logic [15:0] NcrLimit     = 16'(NCR_MAX);
    localparam logic [15:0] BusyLimit    = 16'(BUSY_MAX);
    localparam logic [15:0] TrailerBytes = 16'd4;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [1:0]  type_q, type_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        ack_q, ack_d;
    logic [7:0]  r1_q, r1_d;
    logic [31:0] payload_q, payload_d;
    logic        timeout_q, timeout_d;
    logic [15:0] cntInc;

    assign cntInc = cnt_q + 16'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_HUNT;
            type_q    <= 2'd0;
            byte_q    <= 8'h00;
            cnt_q     <= 16'd0;
            req_q     <= 1'b0;
            ack_q     <= 1'b0;
            r1_q      <= 8'hFF;
            payload_q <= 32'h0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            type_q    <= type_d;
            byte_q    <= byte_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            ack_q     <= ack_d;
            r1_q      <= r1_d;
            payload_q <= payload_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        type_d    = type_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        ack_d     = ack_q;
        r1_d      = r1_q;
        payload_d = payload_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (respRecv_i && !ack_q) begin
                    type_d    = respType_i;
                    timeout_d = 1'b0;
                    payload_d = 32'h0;
                    r1_d      = 8'hFF;
                    cnt_d     = 16'd0;
                    phase_d   = PH_HUNT;
                    state_d   = S_REQ;
                end
            end

            // Holding off until the engine has dropped its previous ack keeps the
            // byte handshake four-phase even straight out of reset.
            S_REQ: begin
                if (!recvAck_i) begin
                    req_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (recvAck_i) begin
                    byte_d  = recvData_i;
                    req_d   = 1'b0;
                    state_d = S_EVAL;
                end
            end

            S_EVAL: begin
                case (phase_q)
                    PH_HUNT: begin
                        if (!byte_q[7]) begin
                            r1_d  = byte_q;
                            cnt_d = 16'd0;
                            if (type_q == 2'd1) begin
                                phase_d = PH_PAYLOAD;
                                state_d = S_REQ;
                            end else if (type_q == 2'd2) begin
                                phase_d = PH_BUSY;
                                state_d = S_REQ;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            cnt_d = cntInc;
                            if (cntInc >= NcrLimit) begin
                                timeout_d = 1'b1;
                                state_d   = S_DONE;
                            end else begin
                                state_d = S_REQ;
                            end
                        end
                    end

                    PH_PAYLOAD: begin
                        payload_d = {payload_q[23:0], byte_q};
                        cnt_d     = cntInc;
                        state_d   = (cntInc >= TrailerBytes) ? S_DONE : S_REQ;
                    end

                    PH_BUSY: begin
                        if (byte_q != 8'h00) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cntInc;
                            if (cntInc >= BusyLimit) begin
                                timeout_d = 1'b1;
                                state_d   = S_DONE;
                            end else begin
                                state_d = S_REQ;
                            end
                        end
                    end

                    default: state_d = S_DONE;
                endcase
            end

            // Ack rises one clock after entering DONE, then waits for the
            // controller to drop its request before returning to idle.
            S_DONE: begin
                if (!ack_q) begin
                    ack_d = 1'b1;
                end else if (!respRecv_i) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign recvReq_o = req_q;
    assign respAck_o = ack_q;
    assign r1_o      = r1_q;
    assign payload_o = payload_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_receive_response.sv
// Scoreboard bench for receive_response: a behavioural SPI byte engine feeds
// queued bytes, expected results are queued per request and checked on RespAck.
module tb_receive_response;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  recvData = 8'hFF;
    logic        recvAckEng = 1'b0;
    logic        holdAck = 1'b0;
    logic        stall = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  respType = 2'd0;
    logic        respRecvA = 1'b0;
    logic        respRecvB = 1'b0;
    logic        recvAck;

    logic        reqA, ackA, toA, reqB, ackB, toB;
    logic [7:0]  r1A, r1B;
    logic [31:0] payA, payB;
    logic        obsReq, obsAck, obsTo;
    logic [7:0]  obsR1;
    logic [31:0] obsPay;

    typedef struct {
        logic [7:0]  r1;
        logic [31:0] payload;
        logic        timeout;
        int          shakes;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] feedQ[$];
    int         totalShakes = 0;
    int         shakeBase = 0;
    int         checkCount = 0;
    int         errorCount = 0;

    always #5 clk = ~clk;

    assign recvAck = recvAckEng | holdAck;
    assign obsReq  = sel ? reqB : reqA;
    assign obsAck  = sel ? ackB : ackA;
    assign obsTo   = sel ? toB  : toA;
    assign obsR1   = sel ? r1B  : r1A;
    assign obsPay  = sel ? payB : payA;

    receive_response dutA (
        .clk_i      (clk),
        .reset_i    (reset),
        .recvData_i (recvData),
        .recvReq_o  (reqA),
        .recvAck_i  (recvAck),
        .respType_i (respType),
        .respRecv_i (respRecvA),
        .respAck_o  (ackA),
        .r1_o       (r1A),
        .payload_o  (payA),
        .timeout_o  (toA)
    );

    receive_response #(.BUSY_MAX(4)) dutB (
        .clk_i      (clk),
        .reset_i    (reset),
        .recvData_i (recvData),
        .recvReq_o  (reqB),
        .recvAck_i  (recvAck),
        .respType_i (respType),
        .respRecv_i (respRecvB),
        .respAck_o  (ackB),
        .r1_o       (r1B),
        .payload_o  (payB),
        .timeout_o  (toB)
    );

    // SPI engine model: acks in the same cycle the request rises, drops the ack
    // once the request falls, and serves 0xFF when nothing is queued.
    always @(posedge clk) begin
        #1;
        if (!holdAck) begin
            if (!obsReq) begin
                recvAckEng = 1'b0;
            end else if (!recvAckEng && !stall) begin
                recvAckEng = 1'b1;
                recvData   = (feedQ.size() > 0) ? feedQ.pop_front() : 8'hFF;
                totalShakes++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Waits for RespAck, pops the scoreboard, checks the result holds while the
    // request stays high, then completes the release half of the handshake.
    task automatic collectResult(output int cycles);
        exp_t e;
        cycles = 0;
        while (obsAck !== 1'b1 && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) respType = ~respType;
        end
        checkOutput("respAckSeen", {31'b0, obsAck}, 32'd1);
        e = expQ.pop_front();
        checkOutput("r1", {24'b0, obsR1}, {24'b0, e.r1});
        checkOutput("payload", obsPay, e.payload);
        checkOutput("timeout", {31'b0, obsTo}, {31'b0, e.timeout});
        checkOutput("handshakes", totalShakes - shakeBase, e.shakes);
        repeat (3) @(negedge clk);
        checkOutput("ackHeld", {31'b0, obsAck}, 32'd1);
        checkOutput("noExtraReq", {31'b0, obsReq}, 32'd0);
        checkOutput("handshakesAfterHold", totalShakes - shakeBase, e.shakes);
        respRecvA = 1'b0;
        respRecvB = 1'b0;
        @(negedge clk);
        checkOutput("ackReleased", {31'b0, obsAck}, 32'd0);
    endtask

    task automatic applyStimulus(input logic useB, input logic [1:0] rtype,
                                 input logic [63:0] seq, input int n,
                                 input logic [7:0] er1, input logic [31:0] epay,
                                 input logic eto, input int eshakes, output int latency);
        int cycles;
        @(negedge clk);
        feedQ.delete();
        for (int i = 0; i < n; i++) feedQ.push_back(seq[63-8*i -: 8]);
        expQ.push_back('{er1, epay, eto, eshakes});
        sel       = useB;
        shakeBase = totalShakes;
        respType  = rtype;
        if (useB) respRecvB = 1'b1;
        else      respRecvA = 1'b1;
        collectResult(cycles);
        latency = cycles - 1;
    endtask

    initial begin
        int lat;
        int cycles;

        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int cycles;

        repeat (3) @(negedge clk);
        checkOutput("resetReq", {31'b0, reqA}, 32'd0);
        checkOutput("resetAck", {31'b0, ackA}, 32'd0);
        checkOutput("resetR1", {24'b0, r1A}, 32'hFF);
        checkOutput("resetPayload", payA, 32'h0);
        checkOutput("resetTimeout", {31'b0, toA}, 32'd0);
        reset = 1'b0;

        applyStimulus(1'b0, 2'd0, 64'hFFFF_0100_0000_0000, 3, 8'h01, 32'h0, 1'b0, 3, lat);
        applyStimulus(1'b0, 2'd0, 64'h0100_0000_0000_0000, 1, 8'h01, 32'h0, 1'b0, 1, lat);
        checkOutput("latencyR1First", lat, 4);
        applyStimulus(1'b0, 2'd1, 64'hFF01_0000_01AA_0000, 6, 8'h01, 32'h0000_01AA, 1'b0, 6, lat);
        applyStimulus(1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8, 8'hFF, 32'h0, 1'b1, 8, lat);
        applyStimulus(1'b0, 2'd2, 64'h0000_0000_0000_FF00, 7, 8'h00, 32'h0, 1'b0, 7, lat);
        applyStimulus(1'b1, 2'd2, 64'h0000_0000_0000_0000, 5, 8'h00, 32'h0, 1'b1, 5, lat);
        applyStimulus(1'b0, 2'd3, 64'hFF7F_0000_0000_0000, 2, 8'h7F, 32'h0, 1'b0, 2, lat);
        applyStimulus(1'b0, 2'd1, 64'h05DE_ADBE_EF00_0000, 5, 8'h05, 32'hDEAD_BEEF, 1'b0, 5, lat);

        // Park the DUT in WAIT, then reset it while the engine holds ack high.
        @(negedge clk);
        feedQ.delete();
        sel       = 1'b0;
        stall     = 1'b1;
        respType  = 2'd0;
        respRecvA = 1'b1;
        cycles    = 0;
        while (reqA !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("reqBeforeReset", {31'b0, reqA}, 32'd1);
        holdAck = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        checkOutput("midResetReq", {31'b0, reqA}, 32'd0);
        checkOutput("midResetAck", {31'b0, ackA}, 32'd0);
        checkOutput("midResetR1", {24'b0, r1A}, 32'hFF);
        reset     = 1'b0;
        respRecvA = 1'b0;
        stall     = 1'b0;
        @(negedge clk);
        expQ.push_back('{8'h05, 32'h0, 1'b0, 1});
        feedQ.push_back(8'h05);
        shakeBase = totalShakes;
        respRecvA = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("noReqWhileAckHigh", {31'b0, reqA}, 32'd0);
        holdAck = 1'b0;
        collectResult(cycles);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/receive_response.md
Name: receive_response

Overview:
- Response-side companion to the SD-card SPI command sender.
- After a command frame has gone out, this block drives the shared SPI byte engine to clock in bytes and hunt for the card's R1 token.
- Optionally collects a 4-byte trailer (R3/R7) or waits out R1b busy.
- Results are returned to the controlling FSM through a four-phase request/acknowledge pair.

Parameters:
- NCR_MAX, 8: maximum bytes clocked while hunting for the R1 token (bit7==0) before declaring timeout.
- BUSY_MAX, 65535: maximum bytes polled while the card holds the data line low (0x00) in R1b busy.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- RecvData  in  8  byte received by SPI engine (valid while RecvAck=1)
- RecvReq  out  1  request to SPI engine to clock one byte (engine transmits 0xFF)
- RecvAck  in  1  SPI engine acknowledge
- RespType  in  2  0=R1, 1=R1+4-byte trailer (R3/R7), 2=R1b, 3=treated as R1
- RespRecv  in  1  start request from controller
- RespAck  out  1  result valid / done acknowledge
- R1  out  8  R1 byte received (0xFF on timeout)
- Payload  out  32  trailer bytes, first received in [31:24]
- Timeout  out  1  R1 hunt or busy wait exceeded limit

Behaviour:
- Reset (sync, highest priority, any state):
  - State=IDLE; RecvReq=0, RespAck=0, R1=8'hFF, Payload=0, Timeout=0.
  - Reset mid-transfer abandons the transfer immediately.
- Byte sub-handshake (four-phase):
  - In REQ, wait for RecvAck==0, then set RecvReq=1 and go to WAIT.
  - In WAIT, on RecvAck==1: register RecvData into a byte latch, set RecvReq=0, go to EVAL.
  - At most one byte is in flight at any time.
  - The block never raises RecvReq while RecvAck is still high, including after a reset.
- IDLE:
  - On RespRecv==1 with RespAck==0: latch RespType, clear Timeout and Payload, set R1=0xFF, zero the 16-bit byte counter, set phase=HUNT, go to REQ.
- EVAL, phase HUNT:
  - Byte bit7==0: R1=byte, counter=0.
    - Type 1: phase=PAYLOAD.
    - Type 2: phase=BUSY.
    - Otherwise: DONE.
  - Byte bit7==1: counter+1.
    - If counter reaches NCR_MAX: Timeout=1, R1 stays 0xFF, go to DONE.
    - Else: REQ.
  - Neither PAYLOAD nor BUSY is entered after a hunt timeout.
- EVAL, phase PAYLOAD:
  - Shift in: Payload = {Payload[23:0], byte}, counter+1.
  - After the 4th byte go to DONE; else REQ.
  - Trailer bytes are accepted unconditionally.
- EVAL, phase BUSY:
  - Byte != 0x00: go to DONE (the non-zero byte is discarded).
  - Byte == 0x00: counter+1.
    - If counter reaches BUSY_MAX: Timeout=1, go to DONE.
    - Else: REQ.
- DONE:
  - RespAck=1. R1, Payload and Timeout are stable from this edge until the next accepted request.
  - When RespRecv==0: RespAck=0, go to IDLE.
  - If RespRecv is held high, stay in DONE with no new request.
- Counter:
  - 16-bit, unsigned compare, no wrap. The limit check uses the post-increment value.
- Latency (engine acks the same cycle RecvReq rises, drops the next cycle):
  - 3 clocks per byte.
  - R1 found on byte 1: RespAck rises 4 clocks after RespRecv is sampled.
- Changes to RespType or RespRecv during a transfer are ignored.

Test Plan:
- RespType=0; engine returns FF,FF,01 -> RecvReq pulses 3 times, R1=8'h01, Timeout=0, Payload=0, RespAck high until RespRecv drops, then low.
- RespType=1; engine returns FF,01,00,00,01,AA -> R1=8'h01, Payload=32'h000001AA, 6 byte handshakes, Timeout=0.
- RespType=0; engine returns 8 bytes of FF -> exactly 8 requests, Timeout=1, R1=8'hFF, no 9th RecvReq.
- RespType=2; engine returns 00(R1), then 00 x5, then FF -> R1=8'h00, 7 handshakes, Timeout=0.
- RespType=2 with BUSY_MAX=4; engine returns 00 then 00 x4 -> Timeout=1 after 5 handshakes.
- Assert Reset while in WAIT with RecvAck held high -> next cycle RecvReq=0, RespAck=0, R1=8'hFF. A new RespRecv raises no RecvReq until RecvAck==0, then completes normally.
